// File: rtl/dino_pkg.sv
// ============================================================================
// Module      : dino_pkg
// Description : Shared game-state encoding and obstacle geometry constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_t;

  // Obstacle footprint per type bit
  localparam int unsigned c_OBS_W0 = 16;
  localparam int unsigned c_OBS_H0 = 32;
  localparam int unsigned c_OBS_W1 = 24;
  localparam int unsigned c_OBS_H1 = 48;

  localparam int unsigned c_GROUND_Y_DEF = 400;
  localparam int unsigned c_SCREEN_W_DEF = 640;

  // x^8 + x^6 + x^5 + x^4 + 1, shift-left form
  localparam logic [7:0] c_LFSR_TAPS = 8'hB8;

endpackage

`default_nettype wire

// File: rtl/obstacle_lfsr.sv
// ============================================================================
// Module      : obstacle_lfsr
// Description : 8-bit Fibonacci LFSR, advances when enabled; exposes the
//               fields the spawner consumes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obstacle_lfsr
  import dino_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  output logic       o_spawn_roll,
  output logic       o_type_roll,
  output logic [3:0] o_gap_roll
);

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb = ^(r_lfsr & c_LFSR_TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

  assign o_spawn_roll = r_lfsr[0];
  assign o_type_roll  = r_lfsr[1];
  assign o_gap_roll   = r_lfsr[7:4];

endmodule

`default_nettype wire

// File: rtl/obstacle_engine.sv
// ============================================================================
// Module      : obstacle_engine
// Description : Obstacle scroll/spawn/retire logic, run/over state and
//               per-pixel obstacle colour flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obstacle_engine
  import dino_pkg::*;
#(
  parameter int         NUM_OBS   = 2,
  parameter int         SCREEN_W  = 640,
  parameter int         GROUND_Y  = 400,
  parameter int         SPEED     = 4,
  parameter int         MIN_GAP   = 160,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  input  logic       i_game_tick,
  input  logic       i_collision,
  input  logic       i_restart,
  output logic       o_color_obstacle,
  output logic       o_game_over,
  output logic       o_running,
  output logic       o_obstacle_passed
);

  localparam logic [9:0] c_GROUND = 10'(GROUND_Y);
  localparam logic [9:0] c_TOP0   = 10'(GROUND_Y - int'(c_OBS_H0));
  localparam logic [9:0] c_TOP1   = 10'(GROUND_Y - int'(c_OBS_H1));
  localparam logic [9:0] c_SPEED  = 10'(SPEED);

  game_state_t r_state, w_state_next;

  logic               r_running, r_game_over, r_passed;
  logic [9:0]         r_gap;
  logic               w_spawn_roll, w_type_roll;
  logic [3:0]         w_gap_roll;
  logic               w_tick_run, w_start, w_spawn, w_found;
  logic [NUM_OBS-1:0] w_act, w_retire, w_hit, w_spawn_sel;

  // Collision has priority over a coincident tick
  assign w_tick_run = (r_state == RUN) && i_game_tick && !i_collision;
  assign w_start    = (r_state != RUN) && i_restart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (i_restart)   w_state_next = RUN;
      RUN:     if (i_collision) w_state_next = OVER;
      OVER:    if (i_restart)   w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_running   <= 1'b0;
      r_game_over <= 1'b0;
      r_passed    <= 1'b0;
    end else begin
      r_running   <= (w_state_next == RUN);
      r_game_over <= (w_state_next == OVER);
      r_passed    <= w_tick_run && (|w_retire);
    end
  end

  obstacle_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk          (clk),
    .rst          (rst),
    .i_en         (w_tick_run),
    .o_spawn_roll (w_spawn_roll),
    .o_type_roll  (w_type_roll),
    .o_gap_roll   (w_gap_roll)
  );

  // Lowest-index slot that is free once this tick's retirements are applied
  always_comb begin
    w_spawn_sel = '0;
    w_found     = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (!(w_act[i] && !w_retire[i]) && !w_found) begin
        w_spawn_sel[i] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

  assign w_spawn = w_tick_run && (r_gap == 10'd0) && w_spawn_roll && w_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap <= 10'd0;
    end else if (w_start) begin
      r_gap <= 10'(MIN_GAP);
    end else if (w_tick_run) begin
      if (w_spawn) begin
        r_gap <= 10'(MIN_GAP) + {3'b000, w_gap_roll, 3'b000};
      end else if (r_gap > c_SPEED) begin
        r_gap <= r_gap - c_SPEED;
      end else begin
        r_gap <= 10'd0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_OBS; gi++) begin : g_slot
    logic        r_act;
    logic        r_type;
    logic [9:0]  r_x;
    logic [10:0] w_right;
    logic [9:0]  w_top;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_act  <= 1'b0;
        r_type <= 1'b0;
        r_x    <= 10'd0;
      end else if (w_start) begin
        r_act  <= 1'b0;
        r_type <= 1'b0;
        r_x    <= 10'd0;
      end else if (w_tick_run) begin
        if (w_spawn && w_spawn_sel[gi]) begin
          r_act  <= 1'b1;
          r_type <= w_type_roll;
          r_x    <= 10'(SCREEN_W);
        end else if (w_retire[gi]) begin
          r_act <= 1'b0;
        end else if (r_act) begin
          r_x <= r_x - c_SPEED;
        end
      end
    end

    // Right edge kept at 11 bits so slots near the edge never wrap
    assign w_right = {1'b0, r_x} + (r_type ? 11'(c_OBS_W1) : 11'(c_OBS_W0));
    assign w_top   = r_type ? c_TOP1 : c_TOP0;

    assign w_act[gi]    = r_act;
    assign w_retire[gi] = r_act && (r_x < c_SPEED);
    assign w_hit[gi]    = r_act
                          && (i_hpos >= r_x) && ({1'b0, i_hpos} < w_right)
                          && (i_vpos >= w_top) && (i_vpos < c_GROUND);
  end

  assign o_color_obstacle  = |w_hit;
  assign o_running         = r_running;
  assign o_game_over       = r_game_over;
  assign o_obstacle_passed = r_passed;

endmodule

`default_nettype wire

// File: tb/tb_obstacle_engine.sv
// ============================================================================
// Module      : tb_obstacle_engine
// Description : Self-checking bench for obstacle_engine against a behavioural
//               game model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obstacle_engine;

  localparam int NUM = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] hpos = '0, vpos = '0;
  logic       game_tick = 1'b0, collision = 1'b0, restart = 1'b0;
  logic       color_obstacle, game_over, running, obstacle_passed;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  obstacle_engine dut (
    .clk               (clk),
    .rst               (rst),
    .i_hpos            (hpos),
    .i_vpos            (vpos),
    .i_game_tick       (game_tick),
    .i_collision       (collision),
    .i_restart         (restart),
    .o_color_obstacle  (color_obstacle),
    .o_game_over       (game_over),
    .o_running         (running),
    .o_obstacle_passed (obstacle_passed)
  );

  // Reference model: 0 idle, 1 run, 2 over
  int       m_state;
  bit       m_act [NUM];
  int       m_x   [NUM];
  int       m_typ [NUM];
  int       m_gap;
  bit [7:0] m_lfsr;
  bit       m_passed;

  function automatic bit [7:0] lfsr_next(input bit [7:0] v);
    bit fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return {v[6:0], fb};
  endfunction

  function automatic bit exp_color(input int h, input int v);
    int w, ht;
    for (int i = 0; i < NUM; i++) begin
      w  = (m_typ[i] != 0) ? 24 : 16;
      ht = (m_typ[i] != 0) ? 48 : 32;
      if (m_act[i] && h >= m_x[i] && h < m_x[i] + w && v >= 400 - ht && v < 400)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_gap = 0; m_lfsr = 8'hA5; m_passed = 0;
    for (int i = 0; i < NUM; i++) begin m_act[i] = 0; m_x[i] = 0; m_typ[i] = 0; end
  endtask

  task automatic model_clear();
    m_state = 1; m_gap = 160;
    for (int i = 0; i < NUM; i++) m_act[i] = 0;
  endtask

  task automatic model_step(input bit t, input bit c, input bit r);
    bit retired;
    int free;
    m_passed = 0;
    if (m_state == 1) begin
      if (c) m_state = 2;
      else if (t) begin
        retired = 0;
        for (int i = 0; i < NUM; i++)
          if (m_act[i]) begin
            if (m_x[i] < 4) begin m_act[i] = 0; retired = 1; end
            else m_x[i] -= 4;
          end
        free = -1;
        for (int i = NUM - 1; i >= 0; i--) if (!m_act[i]) free = i;
        if (m_gap == 0 && m_lfsr[0] && free >= 0) begin
          m_act[free] = 1; m_x[free] = 640; m_typ[free] = m_lfsr[1];
          m_gap = 160 + 8 * int'(m_lfsr[7:4]);
        end else begin
          m_gap = (m_gap > 4) ? m_gap - 4 : 0;
        end
        m_lfsr   = lfsr_next(m_lfsr);
        m_passed = retired;
      end
    end else if (r) begin
      model_clear();
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("color", color_obstacle, exp_color(int'(hpos), int'(vpos)));
    chk("running", running, m_state == 1);
    chk("game_over", game_over, m_state == 2);
    chk("passed", obstacle_passed, m_passed);
  endtask

  task automatic run_cycle(input bit t, input bit c, input bit r, input int h, input int v);
    @(negedge clk);
    game_tick = t; collision = c; restart = r;
    hpos = 10'((h < 0) ? 0 : (h > 1023 ? 1023 : h));
    vpos = 10'(v);
    #1 check_outputs();
    @(posedge clk);
    model_step(t, c, r);
  endtask

  function automatic int pick_h();
    int j;
    j = $urandom_range(0, NUM - 1);
    if (m_act[j] && $urandom_range(0, 3) != 0) return m_x[j] + int'($urandom_range(0, 30)) - 3;
    return int'($urandom_range(0, 700));
  endfunction

  typedef struct {
    int dx;
    int vy;
    bit exp0;
    bit exp1;
  } row_t;
  row_t tbl [10];

  task automatic run_table(input int base);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      game_tick = 0; collision = 0; restart = 0;
      hpos = 10'(base + tbl[k].dx);
      vpos = 10'(tbl[k].vy);
      #1 chk("table_color", color_obstacle, (m_typ[0] != 0) ? tbl[k].exp1 : tbl[k].exp0);
      @(posedge clk);
      model_step(0, 0, 0);
    end
  endtask

  task automatic random_phase(input int n);
    bit t, c, r;
    for (int k = 0; k < n; k++) begin
      t = ($urandom_range(0, 2) == 0);
      c = (m_state == 1) ? ($urandom_range(0, 1499) == 0) : ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 24) == 0);
      run_cycle(t, c, r, pick_h(), int'($urandom_range(340, 405)));
    end
  endtask

  initial begin
    int n;
    tbl[0] = '{dx:  0, vy: 399, exp0: 1, exp1: 1};
    tbl[1] = '{dx: 15, vy: 368, exp0: 1, exp1: 1};
    tbl[2] = '{dx: 16, vy: 380, exp0: 0, exp1: 1};
    tbl[3] = '{dx: 23, vy: 352, exp0: 0, exp1: 1};
    tbl[4] = '{dx: 24, vy: 360, exp0: 0, exp1: 0};
    tbl[5] = '{dx: -1, vy: 380, exp0: 0, exp1: 0};
    tbl[6] = '{dx:  5, vy: 367, exp0: 0, exp1: 1};
    tbl[7] = '{dx:  5, vy: 351, exp0: 0, exp1: 0};
    tbl[8] = '{dx:  5, vy: 400, exp0: 0, exp1: 0};
    tbl[9] = '{dx: 10, vy: 390, exp0: 1, exp1: 1};

    model_reset();
    #1;
    chk("reset_running", running, 1'b0);
    chk("reset_game_over", game_over, 1'b0);
    chk("reset_passed", obstacle_passed, 1'b0);
    chk("reset_color", color_obstacle, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle frames: ticks and a pixel sweep do nothing
    for (int f = 0; f < 3; f++) begin
      run_cycle(1, 0, 0, 640, 390);
      for (int k = 0; k < 6; k++) run_cycle(0, 0, 0, 600 + 10 * k, 360 + 7 * k);
    end

    // Start, then tick until the first spawn
    run_cycle(0, 0, 1, 645, 390);
    n = 0;
    while (!m_act[0] && n < 200) begin
      run_cycle(1, 0, 0, 645, 390);
      run_cycle(0, 0, 0, 645, 390);
      n++;
    end
    if (!m_act[0]) chk("spawn_timeout", 1'b0, 1'b1);
    run_table(m_x[0]);

    // Scroll a little and recheck the footprint
    for (int k = 0; k < 20; k++) run_cycle(1, 0, 0, m_x[0] + 4, 390);
    run_table(m_x[0]);

    // Scroll slot0 off the left edge
    n = 0;
    while (!m_passed && n < 400) begin
      run_cycle(1, 0, 0, pick_h(), 390);
      n++;
    end
    if (!m_passed) chk("retire_timeout", 1'b0, 1'b1);
    run_cycle(0, 0, 0, pick_h(), 390);
    run_cycle(0, 0, 0, pick_h(), 390);

    // Collision coincident with a tick freezes the scene
    for (int k = 0; k < 30; k++) run_cycle(1, 0, 0, pick_h(), 390);
    run_cycle(1, 1, 0, pick_h(), 390);
    for (int k = 0; k < 4; k++) run_cycle(k[0], 0, 0, pick_h(), 385);

    // Restart from OVER clears slots
    run_cycle(0, 0, 1, pick_h(), 390);
    run_cycle(1, 0, 1, pick_h(), 390);
    run_cycle(0, 0, 0, pick_h(), 390);

    random_phase(3000);

    // Asynchronous reset in the middle of a run
    if (m_state != 1) run_cycle(0, 0, 1, 645, 390);
    for (int k = 0; k < 60; k++) run_cycle(1, 0, 0, pick_h(), 390);
    @(negedge clk);
    hpos = 10'(m_act[0] ? m_x[0] + 2 : 645);
    vpos = 10'd390;
    rst = 1'b1;
    #1;
    chk("midreset_running", running, 1'b0);
    chk("midreset_game_over", game_over, 1'b0);
    chk("midreset_passed", obstacle_passed, 1'b0);
    chk("midreset_color", color_obstacle, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run_cycle(0, 0, 1, 645, 390);
    random_phase(800);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
